// File: rtl/morphle_pkg.sv
// Shared token encoding and driver state type for the Morphle cell front-end.
package morphle_pkg;

  localparam logic [1:0] VEMPTY = 2'd0;
  localparam logic [1:0] V0     = 2'd1;
  localparam logic [1:0] V1     = 2'd2;
  localparam logic [1:0] VILL   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_OUT = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_PUBLISH  = 3'd3,
    ST_FAULT    = 3'd4
  } drv_state_t;

  function automatic logic is_illegal(input logic [1:0] tok);
    return tok == VILL;
  endfunction

endpackage

// File: rtl/morphle_sync.sv
// Multi-flop synchronizer for the asynchronous 2-bit cell out bus, plus a
// two-sample compare so bit skew on the dual-rail token is not mistaken for a value.
module morphle_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] d,
  output logic [1:0] value,
  output logic       stable
);

  logic [STAGES-1:0][1:0] chain;
  logic [1:0]             prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign value  = chain[STAGES-1];
  assign stable = (value == prev);

endmodule

// File: rtl/ycfsm_driver.sv
// Clocked valid/ready front-end that drives one asynchronous ycfsm cell through
// a full return-to-empty cycle and reports the captured out token.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  IDLE     | ready for a request (once the cell reset hold has elapsed)
//  WAIT_OUT | in/match driven, waiting for a stable non-empty out token
//  RELEASE  | in/match back to empty, waiting for out to return to empty
//  PUBLISH  | result held on r_* until consumed
//  FAULT    | cell out never emptied; parked until reset
module ycfsm_driver
  import morphle_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 16,
  parameter int RST_HOLD    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [1:0] s_in,
  input  logic [1:0] s_match,
  output logic       y_reset,
  output logic [1:0] y_in,
  output logic [1:0] y_match,
  input  logic [1:0] y_out,
  output logic       r_valid,
  input  logic       r_ready,
  output logic [1:0] r_out,
  output logic       r_timeout,
  output logic       err_stuck
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_HOLD - 1);

  drv_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [RW-1:0] rst_cnt;
  logic [1:0]    y_in_nxt, y_match_nxt, r_out_nxt;
  logic          r_timeout_nxt, err_stuck_nxt;
  logic [1:0]    out_val;
  logic          out_stable;

  morphle_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (y_out),
    .value   (out_val),
    .stable  (out_stable)
  );

  // Both handshake outputs decode registered state only.
  assign s_ready = (state == ST_IDLE) && !y_reset;
  assign r_valid = (state == ST_PUBLISH);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y_reset <= 1'b1;
      rst_cnt <= '0;
    end else if (y_reset) begin
      if (rst_cnt == RST_LAST) y_reset <= 1'b0;
      else                     rst_cnt <= rst_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      y_in      <= VEMPTY;
      y_match   <= VEMPTY;
      r_out     <= VEMPTY;
      r_timeout <= 1'b0;
      err_stuck <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      y_in      <= y_in_nxt;
      y_match   <= y_match_nxt;
      r_out     <= r_out_nxt;
      r_timeout <= r_timeout_nxt;
      err_stuck <= err_stuck_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    y_in_nxt      = y_in;
    y_match_nxt   = y_match;
    r_out_nxt     = r_out;
    r_timeout_nxt = r_timeout;
    err_stuck_nxt = err_stuck;
    cnt_inc       = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    case (state)
      ST_IDLE: begin
        if (s_valid && s_ready) begin
          if (is_illegal(s_in) || is_illegal(s_match)) begin
            r_out_nxt     = VILL;
            r_timeout_nxt = 1'b0;
            state_nxt     = ST_PUBLISH;
          end else begin
            y_in_nxt    = s_in;
            y_match_nxt = s_match;
            cnt_nxt     = '0;
            state_nxt   = ST_WAIT_OUT;
          end
        end
      end

      ST_WAIT_OUT: begin
        cnt_nxt = cnt_inc;
        // A stable token seen on the terminal cycle still counts as a result.
        if (out_stable && (out_val != VEMPTY)) begin
          r_out_nxt     = out_val;
          r_timeout_nxt = 1'b0;
          y_in_nxt      = VEMPTY;
          y_match_nxt   = VEMPTY;
          cnt_nxt       = '0;
          state_nxt     = ST_RELEASE;
        end else if (cnt == CNT_LAST) begin
          r_out_nxt     = VEMPTY;
          r_timeout_nxt = 1'b1;
          y_in_nxt      = VEMPTY;
          y_match_nxt   = VEMPTY;
          cnt_nxt       = '0;
          state_nxt     = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        cnt_nxt     = cnt_inc;
        y_in_nxt    = VEMPTY;
        y_match_nxt = VEMPTY;
        if (out_stable && (out_val == VEMPTY)) begin
          state_nxt = ST_PUBLISH;
        end else if (cnt == CNT_LAST) begin
          err_stuck_nxt = 1'b1;
          state_nxt     = ST_FAULT;
        end
      end

      ST_PUBLISH: begin
        if (r_ready) state_nxt = ST_IDLE;
      end

      ST_FAULT: begin
        y_in_nxt    = VEMPTY;
        y_match_nxt = VEMPTY;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ycfsm_driver.sv
// Directed bench for ycfsm_driver with a behavioural ycfsm cell on the y_* bus.
module tb_ycfsm_driver;
  import morphle_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       r_ready = 1'b0;
  logic [1:0] s_in = 2'd0;
  logic [1:0] s_match = 2'd0;
  logic [1:0] y_out = 2'd0;
  logic       s_ready, y_reset, r_valid, r_timeout, err_stuck;
  logic [1:0] y_in, y_match, r_out;

  int n_vec = 0;
  int n_err = 0;

  int         cell_dly = 0;
  logic       cell_stuck = 1'b0;
  int         cell_cnt = 0;
  logic [1:0] cell_tgt;

  ycfsm_driver #(.SYNC_STAGES(2), .TIMEOUT(16), .RST_HOLD(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_in      (s_in),
    .s_match   (s_match),
    .y_reset   (y_reset),
    .y_in      (y_in),
    .y_match   (y_match),
    .y_out     (y_out),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_out     (r_out),
    .r_timeout (r_timeout),
    .err_stuck (err_stuck)
  );

  always #5 clk = ~clk;

  // Cell: V1,V1 -> V1; V1,V0 -> V0; anything else yields no token.
  function automatic logic [1:0] cellf(input logic [1:0] a, input logic [1:0] m);
    if (a == V1 && m == V1) return V1;
    if (a == V1 && m == V0) return V0;
    return VEMPTY;
  endfunction

  // Out follows its target cell_dly cycles after the target changes (0 = same cycle).
  always @(posedge clk) begin
    #1;
    cell_tgt = y_reset ? VEMPTY : cellf(y_in, y_match);
    if (cell_stuck && y_out != VEMPTY) cell_tgt = y_out;
    if (cell_tgt == y_out) cell_cnt = 0;
    else if (cell_cnt >= cell_dly) begin
      y_out    = cell_tgt;
      cell_cnt = 0;
    end else cell_cnt++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Returns 2 time units after the handshake edge E0.
  task automatic send(input logic [1:0] a, input logic [1:0] m);
    int k = 0;
    while (s_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("send_ready", s_ready, 1);
    s_valid = 1'b1;
    s_in    = a;
    s_match = m;
    tick();
    s_valid = 1'b0;
    s_in    = 2'd0;
    s_match = 2'd0;
  endtask

  task automatic collect(input string tag, input logic [1:0] eo, input logic et);
    int k = 0;
    while (r_valid !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, r_valid, 1);
    chk({tag, "_out"}, r_out, eo);
    chk({tag, "_tmo"}, r_timeout, et);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk({tag, "_done"}, r_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    ticks(3);
    chk("rst_y_reset", y_reset, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_out", r_out, 0);
    chk("rst_r_timeout", r_timeout, 0);
    chk("rst_err_stuck", err_stuck, 0);
    chk("rst_y_in", y_in, 0);
    chk("rst_y_match", y_match, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_y_reset", y_reset, 1);
      chk("hold_s_ready", s_ready, 0);
    end
    tick();
    chk("hold_end_y_reset", y_reset, 0);
    chk("hold_end_s_ready", s_ready, 1);

    // V1,V1 with an immediate cell: minimum latency 8
    cell_dly = 0;
    send(V1, V1);
    chk("v11_y_in", y_in, V1);
    chk("v11_y_match", y_match, V1);
    chk("v11_s_ready", s_ready, 0);
    ticks(4);
    chk("v11_rel_y_in", y_in, 0);
    chk("v11_rel_y_match", y_match, 0);
    ticks(3);
    chk("v11_e7_valid", r_valid, 0);
    tick();
    chk("v11_e8_valid", r_valid, 1);
    chk("v11_e8_out", r_out, V1);
    chk("v11_e8_tmo", r_timeout, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_valid", r_valid, 1);
      chk("hold_out", r_out, V1);
      chk("hold_s_ready", s_ready, 0);
    end
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk("v11_ack_valid", r_valid, 0);
    chk("v11_ack_s_ready", s_ready, 1);

    // V0,V0: no token, timeout after 16 WAIT_OUT cycles
    send(V0, V0);
    chk("v00_y_in", y_in, V0);
    ticks(15);
    chk("v00_e15_y_in", y_in, V0);
    chk("v00_e15_valid", r_valid, 0);
    tick();
    chk("v00_e16_y_in", y_in, 0);
    chk("v00_e16_valid", r_valid, 0);
    tick();
    chk("v00_e17_valid", r_valid, 1);
    chk("v00_e17_out", r_out, 0);
    chk("v00_e17_tmo", r_timeout, 1);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;

    // Illegal request: result one cycle after handshake, cell untouched
    send(2'd3, V0);
    chk("ill_valid", r_valid, 1);
    chk("ill_out", r_out, 2'd3);
    chk("ill_tmo", r_timeout, 0);
    chk("ill_y_in", y_in, 0);
    chk("ill_y_match", y_match, 0);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk("ill_y_in_after", y_in, 0);

    // Two-cycle cell delay, V1,V0: latency 2*2+8 = 12
    cell_dly = 2;
    send(V1, V0);
    ticks(11);
    chk("d2_e11_valid", r_valid, 0);
    tick();
    chk("d2_e12_valid", r_valid, 1);
    chk("d2_e12_out", r_out, V0);
    chk("d2_e12_tmo", r_timeout, 0);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;

    // Back-to-back requests give ordered results
    cell_dly = 1;
    send(V1, V1);
    collect("b2b0", V1, 0);
    send(V1, V0);
    collect("b2b1", V0, 0);
    send(VEMPTY, 2'd3);
    collect("b2b2", 2'd3, 0);

    // Reset during WAIT_OUT
    cell_dly = 2;
    send(V1, V1);
    ticks(2);
    reset_n = 1'b0;
    tick();
    chk("mrst_y_in", y_in, 0);
    chk("mrst_r_valid", r_valid, 0);
    chk("mrst_y_reset", y_reset, 1);
    chk("mrst_s_ready", s_ready, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_hold_y_reset", y_reset, 1);
      chk("mrst_hold_s_ready", s_ready, 0);
    end
    tick();
    chk("mrst_end_y_reset", y_reset, 0);
    chk("mrst_end_s_ready", s_ready, 1);
    chk("mrst_end_valid", r_valid, 0);
    cell_dly = 0;
    send(V1, V1);
    collect("mrst_next", V1, 0);

    // Cell out stuck at V1 after release
    cell_stuck = 1'b1;
    send(V1, V1);
    ticks(19);
    chk("stuck_e19_err", err_stuck, 0);
    tick();
    chk("stuck_e20_err", err_stuck, 1);
    chk("stuck_valid", r_valid, 0);
    chk("stuck_s_ready", s_ready, 0);
    ticks(5);
    chk("stuck_later_s_ready", s_ready, 0);
    chk("stuck_later_err", err_stuck, 1);
    chk("stuck_later_y_in", y_in, 0);
    cell_stuck = 1'b0;
    reset_n = 1'b0;
    tick();
    chk("stuck_rst_err", err_stuck, 0);
    reset_n = 1'b1;
    ticks(4);
    chk("stuck_rst_s_ready", s_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
